// File: rtl/gen_sink_link.sv
// gen_sink_link: source (const/count/ext) -> DEPTH-entry FIFO -> registered sink.
// Define GEN_SINK_LINK_CHECK_EN to add the incrementing-sequence sink checker.
module gen_sink_link #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int INIT  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic [1:0]                 mode_i,
  input  logic                       src_en_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       snk_en_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       dout_vld_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic [7:0]                 err_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] level_q, level_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, dout_q, dout_d, wdata, head;
  logic vld_q, vld_d, ovf_q, ovf_d, src_act, push, pop;
  assign full_o     = level_q == (AW+1)'(DEPTH);
  assign empty_o    = level_q == '0;
  assign level_o    = level_q;
  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;
  assign ovf_o      = ovf_q;
  assign head       = mem_q[rptr_q];
  always_comb begin
    src_act = src_en_i && mode_i != 2'b11;
    push    = src_act && !full_o;
    pop     = snk_en_i && !empty_o;
    wdata   = mode_i == 2'b00 ? INIT_W : mode_i == 2'b01 ? cnt_q : din_i;
    wptr_d  = clr_i ? '0 : push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = clr_i ? '0 : pop ? rptr_q + AW'(1) : rptr_q;
    level_d = clr_i ? '0 : (push && !pop) ? level_q + (AW+1)'(1) :
              (pop && !push) ? level_q - (AW+1)'(1) : level_q;
    cnt_d   = clr_i ? INIT_W : (push && mode_i == 2'b01) ? cnt_q + WIDTH'(1) : cnt_q;
    dout_d  = clr_i ? '0 : pop ? head : dout_q;
    vld_d   = !clr_i && pop;
    ovf_d   = !clr_i && (ovf_q || (src_act && full_o));
  end
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem_q[wptr_q] <= wdata;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= INIT_W;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef GEN_SINK_LINK_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [7:0] err_q, err_d;
  logic chk;
  always_comb begin
    chk   = pop && mode_i == 2'b01;
    exp_d = clr_i ? INIT_W : chk ? head + WIDTH'(1) : exp_q;
    err_d = clr_i ? '0 : (chk && head != exp_q && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q <= INIT_W;
      err_q <= '0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end
  assign err_cnt_o = err_q;
`else
  assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_gen_sink_link.sv
// tb_gen_sink_link: directed bench for gen_sink_link (WIDTH=8, DEPTH=4, INIT=1).
module tb_gen_sink_link;
`ifdef GEN_SINK_LINK_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, src_en = 1'b0, snk_en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] din = 8'h00;
  logic [7:0] dout, err_cnt;
  logic dout_vld, full, empty, ovf;
  logic [2:0] level;
  int passed = 0, total = 0, fails = 0;
  gen_sink_link #(.WIDTH(8), .DEPTH(4), .INIT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .mode_i(mode), .src_en_i(src_en),
    .din_i(din), .snk_en_i(snk_en), .dout_o(dout), .dout_vld_o(dout_vld),
    .level_o(level), .full_o(full), .empty_o(empty), .ovf_o(ovf), .err_cnt_o(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err_cnt, 0);
    step();
    rst_n = 1'b1;
    // fill to full in counting mode, then overflow attempt
    mode = 2'b01; src_en = 1'b1;
    repeat (4) step();
    chk("fill_level", level, 4);
    chk("fill_full", full, 1);
    chk("fill_ovf0", ovf, 0);
    step();
    chk("ovf_set", ovf, 1);
    chk("ovf_level", level, 4);
    src_en = 1'b0; snk_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_dout", dout, i);
      chk("drain_vld", dout_vld, 1);
    end
    step();
    chk("idle_vld", dout_vld, 0);
    chk("idle_hold", dout, 4);
    chk("idle_empty", empty, 1);
    snk_en = 1'b0; src_en = 1'b1;
    step();
    src_en = 1'b0; snk_en = 1'b1;
    step();
    chk("cnt_held", dout, 5);
    chk("ovf_sticky", ovf, 1);
    snk_en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_dout", dout, 0);
    chk("clr_level", level, 0);
    // same-cycle push/pop on empty: push only
    src_en = 1'b1; snk_en = 1'b1;
    step();
    chk("emp_pp_vld", dout_vld, 0);
    chk("emp_pp_level", level, 1);
    for (int k = 1; k <= 300; k++) begin
      step();
      chk("stream_dout", dout, k & 255);
      chk("stream_vld", dout_vld, 1);
      chk("stream_level", level, 1);
    end
    chk("stream_err", err_cnt, 0);
    snk_en = 1'b0;
    repeat (3) step();
    chk("refill_full", full, 1);
    chk("refill_ovf", ovf, 0);
    snk_en = 1'b1;
    step();
    chk("full_pp_dout", dout, 8'h2d);
    chk("full_pp_level", level, 3);
    chk("full_pp_ovf", ovf, 1);
    src_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_pp_drain", dout, 8'h2e + i);
    end
    chk("full_pp_empty", empty, 1);
    chk("full_pp_err", err_cnt, 0);
    // external then constant data, popped while source idle
    snk_en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    mode = 2'b10; din = 8'hA5; src_en = 1'b1;
    step();
    din = 8'h3C;
    step();
    mode = 2'b00;
    step();
    src_en = 1'b0; mode = 2'b11; snk_en = 1'b1;
    step();
    chk("ext_a5", dout, 8'hA5);
    step();
    chk("ext_3c", dout, 8'h3C);
    step();
    chk("const_01", dout, 8'h01);
    snk_en = 1'b0; mode = 2'b01; src_en = 1'b1;
    step();
    src_en = 1'b0; snk_en = 1'b1;
    step();
    chk("cnt_untouched", dout, 8'h01);
    // checker: out-of-sequence word queued from external mode
    snk_en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; src_en = 1'b1;
    repeat (2) step();
    mode = 2'b10; din = 8'h7F;
    step();
    src_en = 1'b0; mode = 2'b01; snk_en = 1'b1;
    step();
    chk("chk_d1", dout, 1);
    step();
    chk("chk_d2", dout, 2);
    step();
    chk("chk_d7f", dout, 8'h7F);
    chk("chk_err", err_cnt, EXP_ERR);
    snk_en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("chk_clr_err", err_cnt, 0);
    chk("chk_clr_dout", dout, 0);
    snk_en = 1'b1;
    step();
    chk("chk_clr_pop_vld", dout_vld, 0);
    chk("chk_clr_pop_dout", dout, 0);
    // asynchronous reset mid-burst
    snk_en = 1'b0; src_en = 1'b1;
    repeat (3) step();
    chk("burst_level", level, 3);
    snk_en = 1'b1;
    step();
    chk("burst_dout", dout, 1);
    chk("burst_level2", level, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_vld", dout_vld, 0);
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    src_en = 1'b0; snk_en = 1'b0;
    step();
    rst_n = 1'b1;
    snk_en = 1'b1;
    step();
    chk("post_rst_nopop", dout_vld, 0);
    snk_en = 1'b0; src_en = 1'b1;
    step();
    chk("post_rst_level", level, 1);
    src_en = 1'b0; snk_en = 1'b1;
    step();
    chk("post_rst_dout", dout, 1);
    chk("post_rst_vld", dout_vld, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gen_sink_link.md
Name: gen_sink_link

Overview:
- Parametrised successor to the fixed producer→consumer register pair.
- Contains a configurable source (constant, incrementing, or external data), a DEPTH-entry synchronous FIFO, and a registered sink.
- Used as a self-contained link/loopback block for datapath bring-up between a producer and consumer in the same clock domain.

Parameters:
- WIDTH, 8: data width in bits; must be ≥1.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- INIT, 1: constant-mode value and counter reset value; truncated to WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; active high.
- mode  in  2  source mode: 00 constant INIT, 01 incrementing counter, 10 external din, 11 source idle.
- src_en  in  1  source push request.
- din  in  WIDTH  external data, used in mode 10.
- snk_en  in  1  sink pop request.
- dout  out  WIDTH  last popped word, registered.
- dout_vld  out  1  one-cycle pulse when dout updates.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- ovf  out  1  sticky: push attempted while full.
- err_cnt  out  8  checker mismatch count; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous): dout=0, dout_vld=0, level=0, empty=1, full=0, ovf=0, err_cnt=0. Read/write pointers and counter (cnt) go to 0, 0, INIT.
- push = src_en & (mode!=11) & !full.
- Push data is selected by mode: 00 → INIT, 01 → cnt, 10 → din.
- cnt advances (cnt+1, mod 2^WIDTH) only on an accepted push in mode 01. It holds its value otherwise, including across mode changes.
- src_en & (mode!=11) & full: no write, cnt holds, ovf set to 1 until clr or reset.
- pop = snk_en & !empty. On the pop edge, dout ← FIFO head and dout_vld=1 for exactly that cycle; otherwise dout_vld=0 and dout holds.
- No bypass: when empty, a same-cycle push and pop performs only the push.
- Full: a same-cycle pop and push request performs only the pop. full is evaluated before the edge.
- Push and pop in the same cycle with 0<level<DEPTH: both execute, level unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. level is a separate counter (+1 on push only, −1 on pop only).
- Latency: a word pushed at edge N is at the head after edge N. Earliest dout/dout_vld is edge N+1 if snk_en=1 in that cycle.
- FIFO order is strict; data is never lost or duplicated.
- full, empty and level are registered-derived, valid the cycle after each edge.
- clr=1 has priority over push and pop. Next edge: FIFO flushed (pointers=0, level=0), cnt=INIT, dout=0, dout_vld=0, ovf=0, err_cnt=0.
- Reset asserted mid-transfer discards all FIFO contents immediately.
- Mode change mid-stream affects only subsequent pushes. Entries already queued are unchanged.

Optional Feature:
- Macro: GEN_SINK_LINK_CHECK_EN.
- With the macro defined: sink checker register exp (reset/clr → INIT). On each pop while mode==01: if head≠exp, err_cnt increments, saturating at 255. In all cases exp ← head+1 (mod 2^WIDTH) to resync. Pops in other modes leave exp and err_cnt unchanged.
- Without the macro: no checker logic; err_cnt is tied to 0.

Test Plan:
- Reset, then mode=01, INIT=1, src_en=1 for 4 cycles, snk_en=0 → full=1, level=4. Next pushes give ovf=1, cnt=5 held. Then snk_en=1 → dout sequence 1,2,3,4, each with a single dout_vld pulse.
- Continuous src_en=snk_en=1 in mode 01, WIDTH=8, 300 cycles → level stable at 1, dout wraps 255→0, err_cnt=0 with checker enabled.
- Empty FIFO, push and pop in same cycle → no dout_vld that cycle, level=1. Full FIFO, push and pop in same cycle → level=3, no write, ovf=1.
- Mode 10: din=0xA5 then 0x3C pushed; switch to mode 00 and push → pops yield 0xA5, 0x3C, 0x01. cnt unchanged.
- Checker enabled: mode 01, queue 1,2; switch to mode 10, push 0x7F; return to mode 01 and pop all → err_cnt=1 (0x7F≠3). Pop after clr → err_cnt=0, dout=0.
- rst pulsed low asynchronously mid-burst (level=3) → outputs immediately at reset values. After release, first pop only follows a new push, and yields INIT in mode 01.
